// File: rtl/stream_scalar_reduce.sv
// Streaming matrix-to-scalar reduction (signed sum or signed max) with an
// AXI-Stream style input and output and a sticky input-tlast consistency flag.
module stream_scalar_reduce #(
    parameter int X_W          = 8,
    parameter int Y_W          = 32,
    parameter int MATRIXSIZE_W = 24,
    parameter int MODE         = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [X_W-1:0]          in_tdata,
    input  logic                    in_tlast,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    output logic [Y_W-1:0]          out_tdata,
    output logic                    out_tlast,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    input  logic [MATRIXSIZE_W-1:0] DIM1,
    input  logic [MATRIXSIZE_W-1:0] DIM2,
    output logic                    err_tlast
);

    // Wide enough to sum a full DIM1 x DIM2 matrix of X_W-bit elements.
    localparam int ACC_W = X_W + 2 * MATRIXSIZE_W;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        ACC   = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [MATRIXSIZE_W-1:0] col_q;
    logic [MATRIXSIZE_W-1:0] row_q;
    logic [MATRIXSIZE_W-1:0] col_max;
    logic [MATRIXSIZE_W-1:0] row_max;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic [Y_W-1:0]          result;
    logic [Y_W-1:0]          out_data_q;
    logic                    err_q;

    logic in_hs;
    logic out_hs;
    logic col_last;
    logic row_last;
    logic final_beat;
    logic first_beat;

    assign col_max    = DIM2 - MATRIXSIZE_W'(1);
    assign row_max    = DIM1 - MATRIXSIZE_W'(1);
    assign col_last   = (col_q == col_max);
    assign row_last   = (row_q == row_max);
    assign final_beat = col_last & row_last;
    assign first_beat = (col_q == '0) && (row_q == '0);

    assign in_hs  = in_tvalid & in_tready;
    assign out_hs = out_tvalid & out_tready;

    assign x_ext = {{(ACC_W - X_W){in_tdata[X_W-1]}}, in_tdata};

    always_comb begin
        acc_next = acc_q + x_ext;
        if (MODE != 0) begin
            // Max mode: the first beat of each matrix seeds the running maximum.
            if (first_beat || (x_ext > acc_q)) acc_next = x_ext;
            else                               acc_next = acc_q;
        end
    end

    generate
        if (ACC_W > Y_W) begin : g_saturate
            localparam logic signed [ACC_W-1:0] SAT_MAX =
                {{(ACC_W - Y_W + 1){1'b0}}, {(Y_W - 1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN =
                {{(ACC_W - Y_W + 1){1'b1}}, {(Y_W - 1){1'b0}}};
            always_comb begin
                if (acc_next > SAT_MAX)      result = SAT_MAX[Y_W-1:0];
                else if (acc_next < SAT_MIN) result = SAT_MIN[Y_W-1:0];
                else                         result = acc_next[Y_W-1:0];
            end
        end else if (ACC_W == Y_W) begin : g_direct
            assign result = acc_next;
        end else begin : g_extend
            assign result = {{(Y_W - ACC_W){acc_next[ACC_W-1]}}, acc_next};
        end
    endgenerate

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        in_tready  = 1'b0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        case (state_q)
            RESET: state_d = ACC;
            ACC: begin
                in_tready = 1'b1;
                if (in_hs && final_beat) state_d = OUT;
            end
            OUT: begin
                out_tvalid = 1'b1;
                out_tlast  = 1'b1;
                if (out_tready) state_d = ACC;
            end
            default: state_d = RESET;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET;
            col_q      <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_hs) begin
                if (final_beat) begin
                    col_q      <= '0;
                    row_q      <= '0;
                    out_data_q <= result;
                end else if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + MATRIXSIZE_W'(1);
                end else begin
                    col_q <= col_q + MATRIXSIZE_W'(1);
                end
                acc_q <= acc_next;
                // Upstream tlast is only audited; counting ignores it.
                if (in_tlast != final_beat) err_q <= 1'b1;
            end else if (out_hs) begin
                acc_q <= '0;
            end
        end
    end

    assign out_tdata = out_data_q;
    assign err_tlast = err_q;

endmodule

// File: doc/stream_scalar_reduce.md
STREAM_SCALAR_REDUCE -- requirements
Module: stream_scalar_reduce

Interface
REQ-001 SHALL have parameter X_W, default 8, giving the signed input element width.
REQ-002 SHALL have parameter Y_W, default 32, giving the signed output scalar width.
REQ-003 SHALL have parameter MATRIXSIZE_W, default 24, giving the dimension and counter width.
REQ-004 SHALL have parameter MODE, default 0, selecting the reduction: 0 = signed sum, 1 = signed max.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port in_tdata, input, X_W bits, signed matrix element.
REQ-008 SHALL have port in_tlast, input, 1 bit, upstream end-of-matrix marker; checked only, never used for termination.
REQ-009 SHALL have port in_tvalid, input, 1 bit, and port in_tready, output, 1 bit.
REQ-010 SHALL have port out_tdata, output, Y_W bits, signed reduced scalar.
REQ-011 SHALL have port out_tlast, output, 1 bit, and port out_tvalid, output, 1 bit.
REQ-012 SHALL have port out_tready, input, 1 bit.
REQ-013 SHALL have ports DIM1 and DIM2, input, MATRIXSIZE_W bits each, giving row and column counts; they are held static during a reduction.
REQ-014 SHALL have port err_tlast, output, 1 bit, sticky in_tlast mismatch flag.

Function
REQ-015 SHALL implement an FSM with states RESET, ACC and OUT; RESET goes to ACC unconditionally on the next edge.
REQ-016 ACC: in_tready=1, out_tvalid=0; every input handshake (in_tvalid & in_tready) consumes one element.
REQ-017 SHALL keep column counter col (0..DIM2-1) and row counter row (0..DIM1-1); on each input handshake col increments; at DIM2-1, col wraps to 0 and row increments.
REQ-018 The final beat is the handshake with col==DIM2-1 and row==DIM1-1; on it, both counters clear and the state goes to OUT on the next edge.
REQ-019 Latency: out_tvalid SHALL rise exactly one cycle after the final input handshake.
REQ-020 MODE 0: the accumulator width SHALL be X_W+2*MATRIXSIZE_W, signed; it adds the sign-extended in_tdata per handshake with no internal overflow.
REQ-021 MODE 0 output: the accumulator is saturated to the signed Y_W range, giving [-2^(Y_W-1), 2^(Y_W-1)-1].
REQ-022 MODE 1: the first beat of a reduction loads the accumulator; later beats keep the signed maximum; the output is sign-extended to Y_W.
REQ-023 OUT: out_tvalid=1, out_tlast=1, in_tready=0; out_tdata is the registered result and stays stable until the handshake.
REQ-024 An out_tvalid & out_tready handshake in OUT SHALL clear the accumulator and return to ACC on the next edge, so the next in_tready rises one cycle after the output handshake.
REQ-025 Backpressure: OUT SHALL hold indefinitely while out_tready=0; no input is accepted while in OUT.
REQ-026 err_tlast SHALL be set on any input handshake where in_tlast differs from the final-beat condition; it clears only on reset.
REQ-027 A tlast mismatch SHALL NOT alter counting or termination.
REQ-028 DIM1=1, DIM2=1: every input beat is a final beat, producing one output per input.
REQ-029 DIM1=0 or DIM2=0 is outside the operating range; no behaviour is guaranteed.
REQ-030 Counter compares SHALL be full MATRIXSIZE_W width; maximum dimensions wrap correctly with no extra beats.

Reset
REQ-031 Asserting rst SHALL immediately force state RESET, col=0, row=0, accumulator 0, out_tdata 0, out_tvalid 0, out_tlast 0, in_tready 0, err_tlast 0.
REQ-032 Reset mid-reduction or mid-OUT SHALL discard partial results; after deassertion, in_tready=1 from the second rising edge.

Verification
REQ-033 MODE 0, DIM1=2, DIM2=3, inputs 1..6 with in_tlast on beat 6 -> one output 21, out_tlast=1, err_tlast=0.
REQ-034 MODE 1, DIM1=1, DIM2=4, inputs -5,7,-128,3 -> output 7; then a second matrix -9,-2,-8,-3 -> output -2 (accumulator reset between matrices).
REQ-035 MODE 0, Y_W=8, X_W=8, DIM1=1, DIM2=4, inputs 127,127,127,127 -> output 127 (saturated); inputs -128 x4 -> -128.
REQ-036 out_tready held 0 for 10 cycles while in OUT -> out_tvalid and out_tdata stable, in_tready=0 throughout; output handshake on cycle 11 -> in_tready=1 one cycle later.
REQ-037 DIM1=2, DIM2=2, in_tlast on beat 2 only -> err_tlast=1 from beat 2 onward, output still after beat 4 with the correct sum.
REQ-038 rst asserted after 3 of 6 beats, then 6 fresh beats 1..6 -> single output 21, no stale data, all outputs 0 during reset.
